// File: rtl/e3_conv_sched.sv
// e3_conv_sched: round-robin front end that time-shares one serial Excess-3 -> BCD converter among NREQ requesters.
// Optional macro E3_CONV_SELF_CHECK_EN adds a sticky chk_fail output comparing each converted digit with d-3.
module e3_conv_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_digit,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_bcd,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_err,
  output logic              cv_x,
  output logic              cv_rst_n,
  input  logic              cv_z
`ifdef E3_CONV_SELF_CHECK_EN
  , output logic            chk_fail
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;

  state_t          r_state, w_state;
  logic [1:0]      r_bitcnt, w_bitcnt;
  logic [IDW-1:0]  r_rr, w_rr;
  logic [3:0]      r_digit, w_digit;
  logic [2:0]      r_bcd, w_bcd;
  logic [NREQ-1:0] r_ack, w_ack;
  logic            r_rsp_valid, w_rsp_valid;
  logic [3:0]      r_rsp_bcd, w_rsp_bcd;
  logic [IDW-1:0]  r_rsp_id, w_rsp_id;
  logic            r_rsp_err, w_rsp_err;
  logic            r_cv_x, w_cv_x;
  logic            r_cv_rst_n, w_cv_rst_n;

  logic            w_found;
  logic [IDW-1:0]  w_g, w_idx;
  logic [3:0]      w_sel;
  logic            w_sel_ok;
  logic [3:0]      w_asm;

  // First requester found searching upward from the one after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_rr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_g     = w_idx;
      end
    end
  end

  assign w_sel    = req_digit[{w_g, 2'b00} +: 4];
  assign w_sel_ok = (w_sel >= 4'd3) && (w_sel <= 4'd12);
  assign w_asm    = {cv_z, r_bcd};

  always_comb begin
    w_state     = r_state;
    w_bitcnt    = r_bitcnt;
    w_rr        = r_rr;
    w_digit     = r_digit;
    w_bcd       = r_bcd;
    w_ack       = '0;
    w_rsp_valid = r_rsp_valid;
    w_rsp_bcd   = r_rsp_bcd;
    w_rsp_id    = r_rsp_id;
    w_rsp_err   = r_rsp_err;
    w_cv_x      = 1'b0;
    w_cv_rst_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_rr     = w_g;
          w_ack    = NREQ'(1) << w_g;
          w_digit  = w_sel;
          w_rsp_id = w_g;
          if (w_sel_ok) begin
            w_cv_rst_n = 1'b1;
            w_cv_x     = w_sel[0];
            w_bitcnt   = 2'd0;
            w_state    = S_SHIFT;
          end else begin
            // Out-of-range codes are answered directly; the converter stays in reset.
            w_rsp_bcd   = 4'd0;
            w_rsp_err   = 1'b1;
            w_rsp_valid = 1'b1;
            w_state     = S_RESP;
          end
        end
      end
      S_SHIFT: begin
        if (r_bitcnt != 2'd3) begin
          w_bcd[r_bitcnt] = cv_z;
          w_bitcnt        = r_bitcnt + 2'd1;
          w_cv_rst_n      = 1'b1;
          w_cv_x          = r_digit[r_bitcnt + 2'd1];
        end else begin
          w_rsp_bcd   = w_asm;
          w_rsp_err   = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_rr        <= IDW'(NREQ - 1);
      r_digit     <= '0;
      r_bcd       <= '0;
      r_ack       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_bcd   <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
      r_cv_x      <= 1'b0;
      r_cv_rst_n  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bitcnt    <= w_bitcnt;
      r_rr        <= w_rr;
      r_digit     <= w_digit;
      r_bcd       <= w_bcd;
      r_ack       <= w_ack;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_bcd   <= w_rsp_bcd;
      r_rsp_id    <= w_rsp_id;
      r_rsp_err   <= w_rsp_err;
      r_cv_x      <= w_cv_x;
      r_cv_rst_n  <= w_cv_rst_n;
    end
  end

`ifdef E3_CONV_SELF_CHECK_EN
  logic r_chk_fail;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      r_chk_fail <= 1'b0;
    else if (r_state == S_SHIFT && r_bitcnt == 2'd3 && w_asm != (r_digit - 4'd3))
      r_chk_fail <= 1'b1;
  end

  assign chk_fail = r_chk_fail;
`endif

  assign ack       = r_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_bcd   = r_rsp_bcd;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign cv_x      = r_cv_x;
  assign cv_rst_n  = r_cv_rst_n;

endmodule

// File: tb/tb_e3_conv_sched.sv
// Bench for e3_conv_sched: behavioural serial Excess-3 converter plus a d-3 / round-robin reference model.
// Build with E3_CONV_SELF_CHECK_EN defined to exercise chk_fail.
module tb_e3_conv_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] req_digit = '0;
  logic [NREQ-1:0]   ack;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [3:0]        rsp_bcd;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              cv_x;
  logic              cv_rst_n;
  logic              cv_z;
`ifdef E3_CONV_SELF_CHECK_EN
  logic              chk_fail;
`endif

  int checks = 0;
  int failures = 0;
  int model_rr = NREQ - 1;

  e3_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .req_digit(req_digit), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bcd(rsp_bcd), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .cv_x(cv_x), .cv_rst_n(cv_rst_n), .cv_z(cv_z)
`ifdef E3_CONV_SELF_CHECK_EN
    , .chk_fail(chk_fail)
`endif
  );

  always #5 Clk = ~Clk;

  // Serial subtract-3 converter, LSB first, Mealy output.
  logic [1:0] c_idx;
  logic       c_b, c_s, force_z0 = 1'b0;
  assign c_s  = (c_idx < 2'd2);
  assign cv_z = force_z0 ? 1'b0 : (cv_x ^ c_s ^ c_b);
  always @(posedge Clk or negedge cv_rst_n) begin
    if (!cv_rst_n) begin
      c_idx <= 2'd0;
      c_b   <= 1'b0;
    end else begin
      c_idx <= c_idx + 2'd1;
      c_b   <= (~cv_x & (c_s | c_b)) | (c_s & c_b);
    end
  end

  function automatic int model_grant(input logic [NREQ-1:0] r, input int rr);
    for (int k = 1; k <= NREQ; k++)
      if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    tick();
    Rst = 1'b0;
    req = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    Rst = 1'b1;
    model_rr = NREQ - 1;
  endtask

  // One lone request driven to completion; results left in rq_* for the caller to judge.
  logic [NREQ-1:0] rq_ack;
  logic [3:0]      rq_bcd, rq_xb;
  logic [IDW-1:0]  rq_id;
  logic            rq_err, rq_vafter;
  int              rq_lat, rq_rsthi, rq_xack;
  bit              rq_to;

  task automatic run_req(input int id, input logic [3:0] d);
    bit got;
    rq_to = 0; rq_ack = '0; rq_bcd = '0; rq_id = '0; rq_err = 0; rq_lat = -1;
    rq_rsthi = 0; rq_xb = '0; rq_xack = 0; rq_vafter = 1'b1;
    req_digit[4*id +: 4] = d;
    rsp_ready = 1'b1;
    req[id] = 1'b1;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      if (ack !== '0) begin got = 1; rq_ack = ack; end
    end
    req[id] = 1'b0;
    if (!got) begin rq_to = 1; return; end
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (n > 0 && ack !== '0) rq_xack++;
      if (cv_rst_n === 1'b1) begin
        if (rq_rsthi < 4) rq_xb[rq_rsthi] = cv_x;
        rq_rsthi++;
      end
      if (rsp_valid === 1'b1) begin
        got = 1; rq_lat = n; rq_bcd = rsp_bcd; rq_id = rsp_id; rq_err = rsp_err;
      end else tick();
    end
    if (!got) begin rq_to = 1; return; end
    tick();
    rq_vafter = rsp_valid;
  endtask

  task automatic test_reset();
    req = '1;
    tick(); tick();
    checks++;
    if ({ack, rsp_valid, rsp_bcd, rsp_id, rsp_err, cv_x, cv_rst_n} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b v=%b bcd=%h id=%0d err=%b x=%b rstn=%b required all 0",
               ack, rsp_valid, rsp_bcd, rsp_id, rsp_err, cv_x, cv_rst_n);
    end
    req = '0;
    Rst = 1'b1;
    tick();
    checks++;
    if ({ack, rsp_valid, cv_rst_n, cv_x} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got ack=%b v=%b rstn=%b x=%b required 0", ack, rsp_valid, cv_rst_n, cv_x);
    end
  endtask

  task automatic test_single();
    do_reset();
    run_req(0, 4'b1000);
    checks++;
    if (rq_to) begin failures++; $display("FAIL single_timeout: got no completion required a response"); end
    checks++;
    if (rq_ack !== 4'b0001 || rq_xack !== 0) begin
      failures++; $display("FAIL single_ack: got %b (extra %0d) required 0001 single pulse", rq_ack, rq_xack);
    end
    checks++;
    if (rq_xb !== 4'b1000 || rq_rsthi !== 4) begin
      failures++; $display("FAIL single_cv_x: got bits %b over %0d cycles required 1000 over 4", rq_xb, rq_rsthi);
    end
    checks++;
    if (rq_lat !== 4) begin failures++; $display("FAIL single_latency: got %0d required 4", rq_lat); end
    checks++;
    if ({rq_bcd, rq_id, rq_err} !== {4'b0101, 2'd0, 1'b0}) begin
      failures++; $display("FAIL single_rsp: got bcd=%b id=%0d err=%b required 0101 0 0", rq_bcd, rq_id, rq_err);
    end
    checks++;
    if (rq_vafter !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %b required 0", rq_vafter); end
  endtask

  task automatic test_invalid();
    run_req(1, 4'b0001);
    checks++;
    if (rq_to || rq_ack !== 4'b0010) begin
      failures++; $display("FAIL invalid_ack: got %b (timeout %0d) required 0010", rq_ack, rq_to);
    end
    checks++;
    if ({rq_bcd, rq_id, rq_err} !== {4'b0000, 2'd1, 1'b1} || rq_lat !== 0) begin
      failures++;
      $display("FAIL invalid_rsp: got bcd=%b id=%0d err=%b lat=%0d required 0000 1 1 lat 0", rq_bcd, rq_id, rq_err, rq_lat);
    end
    checks++;
    if (rq_rsthi !== 0) begin failures++; $display("FAIL invalid_cv_rst: got %0d cycles high required 0", rq_rsthi); end
  endtask

  int arb_ord[4];
  int arb_cnt;

  task automatic arb_run(input logic [NREQ-1:0] init, input logic [NREQ-1:0] add_after_first);
    logic [NREQ-1:0] want;
    for (int i = 0; i < 4; i++) arb_ord[i] = -1;
    for (int i = 0; i < NREQ; i++) req_digit[4*i +: 4] = 4'd5;
    rsp_ready = 1'b1;
    want = init;
    req = want;
    arb_cnt = 0;
    for (int n = 0; n < 200 && arb_cnt < 4; n++) begin
      tick();
      req = want;
      if (ack !== '0) begin
        arb_ord[arb_cnt] = oh2i(ack);
        if (arb_cnt == 0) want = want | add_after_first;
        req = want & ~ack;
        arb_cnt++;
      end
    end
    req = '0;
    for (int n = 0; n < 8; n++) tick();
  endtask

  task automatic test_arbitration();
    int exp_a[4] = '{0, 2, 0, 2};
    int exp_b[4] = '{0, 2, 3, 0};
    do_reset();
    arb_run(4'b0101, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arb_ord[i] !== exp_a[i]) begin
        failures++; $display("FAIL arb_0101_grant%0d: got %0d required %0d", i, arb_ord[i], exp_a[i]);
      end
    end
    do_reset();
    arb_run(4'b0101, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arb_ord[i] !== exp_b[i]) begin
        failures++; $display("FAIL arb_add3_grant%0d: got %0d required %0d", i, arb_ord[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset();
    rsp_ready = 1'b0;
    req_digit[8 +: 4]  = 4'd9;
    req_digit[12 +: 4] = 4'd11;
    req = 4'b1100;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); if (ack !== '0) got = 1; end
    checks++;
    if (ack !== 4'b0100) begin failures++; $display("FAIL bp_first_ack: got %b required 0100", ack); end
    req = 4'b1000;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); if (rsp_valid === 1'b1) got = 1; end
    for (int n = 0; n < 10; n++) begin
      checks++;
      if ({rsp_valid, rsp_bcd, rsp_id, rsp_err, ack} !== {1'b1, 4'd6, 2'd2, 1'b0, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b bcd=%h id=%0d err=%b ack=%b required 1 6 2 0 0000",
                 n, rsp_valid, rsp_bcd, rsp_id, rsp_err, ack);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (ack !== '0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release: got ack=%b v=%b required 0000 0", ack, rsp_valid);
    end
    tick();
    checks++;
    if (ack !== 4'b1000) begin failures++; $display("FAIL bp_second_ack: got %b required 1000", ack); end
    req = '0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); if (rsp_valid === 1'b1) got = 1; end
    checks++;
    if ({rsp_valid, rsp_bcd, rsp_id} !== {1'b1, 4'd8, 2'd3}) begin
      failures++; $display("FAIL bp_second_rsp: got v=%b bcd=%h id=%0d required 1 8 3", rsp_valid, rsp_bcd, rsp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    bit got;
    do_reset();
    req_digit[0 +: 4] = 4'b1100;
    req = 4'b0001;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); if (ack !== '0) got = 1; end
    checks++;
    if (ack !== 4'b0001) begin failures++; $display("FAIL mid_ack: got %b required 0001", ack); end
    req = '0;
    tick();
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    checks++;
    if ({ack, rsp_valid, rsp_bcd, rsp_id, rsp_err, cv_x, cv_rst_n} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got v=%b bcd=%h x=%b rstn=%b required all 0", rsp_valid, rsp_bcd, cv_x, cv_rst_n);
    end
    tick(); tick();
    Rst = 1'b1;
    model_rr = NREQ - 1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || ack !== '0) begin
        failures++; $display("FAIL mid_no_rsp%0d: got v=%b ack=%b required 0 0000", n, rsp_valid, ack);
      end
    end
    run_req(0, 4'b1100);
    checks++;
    if (rq_to || rq_ack !== 4'b0001 || {rq_bcd, rq_id, rq_err} !== {4'b1001, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_rerequest: got ack=%b bcd=%b id=%0d err=%b required 0001 1001 0 0", rq_ack, rq_bcd, rq_id, rq_err);
    end
  endtask

  task automatic test_exhaustive();
    int perm[16];
    int id, j, t;
    logic [3:0] d, eb;
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i)); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 16; i++) begin
      d  = 4'(perm[i]);
      id = int'($urandom_range(0, NREQ - 1));
      ok = (d >= 3) && (d <= 12);
      eb = ok ? d - 4'd3 : 4'd0;
      run_req(id, d);
      checks++;
      if (rq_to || rq_ack !== (NREQ'(1) << id) || rq_xack !== 0) begin
        failures++; $display("FAIL exh_ack d=%0d: got %b required one pulse of bit %0d", d, rq_ack, id);
      end
      checks++;
      if ({rq_bcd, rq_err, rq_id} !== {eb, !ok, IDW'(id)}) begin
        failures++;
        $display("FAIL exh_rsp d=%0d: got bcd=%0d err=%b id=%0d required %0d %b %0d", d, rq_bcd, rq_err, rq_id, eb, !ok, id);
      end
      checks++;
      if (rq_lat !== (ok ? 4 : 0) || rq_rsthi !== (ok ? 4 : 0)) begin
        failures++;
        $display("FAIL exh_timing d=%0d: got lat=%0d rsthi=%0d required %0d", d, rq_lat, rq_rsthi, ok ? 4 : 0);
      end
      if (ok) begin
        checks++;
        if (rq_xb !== d) begin failures++; $display("FAIL exh_serial d=%0d: got %b required %b", d, rq_xb, d); end
      end
    end
`ifdef E3_CONV_SELF_CHECK_EN
    checks++;
    if (chk_fail !== 1'b0) begin failures++; $display("FAIL exh_chk_fail: got %b required 0", chk_fail); end
`endif
  endtask

  task automatic test_back_to_back();
    int exp_id_q[$];
    logic [3:0] exp_d_q[$];
    logic [3:0] dig [NREQ];
    logic [3:0] ed, eb, hb;
    logic [IDW-1:0] hid;
    logic he;
    int g, ei, budget;
    bit seen;
    do_reset();
    for (int round = 0; round < 20; round++) begin
      for (int i = 0; i < NREQ; i++) begin
        dig[i] = 4'($urandom_range(0, 15));
        req_digit[4*i +: 4] = dig[i];
      end
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      seen = 0;
      budget = 0;
      while ((req != '0 || exp_id_q.size() > 0 || rsp_valid === 1'b1) && budget < 400) begin
        tick();
        budget++;
        if (ack !== '0) begin
          g = model_grant(req, model_rr);
          checks++;
          if (g < 0 || ack !== (NREQ'(1) << g)) begin
            failures++; $display("FAIL b2b_grant r%0d: got %b required bit %0d", round, ack, g);
          end
          if (g >= 0) begin
            model_rr = g;
            exp_id_q.push_back(g);
            exp_d_q.push_back(dig[g]);
          end
          req = req & ~ack;
        end
        if (rsp_valid !== 1'b1) seen = 0;
        else if (!seen) begin
          seen = 1;
          checks++;
          if (exp_id_q.size() == 0) begin
            failures++; $display("FAIL b2b_unexpected_rsp r%0d: got id=%0d required none", round, rsp_id);
          end else begin
            ei = exp_id_q.pop_front();
            ed = exp_d_q.pop_front();
            eb = (ed >= 3 && ed <= 12) ? ed - 4'd3 : 4'd0;
            if ({rsp_id, rsp_err, rsp_bcd} !== {IDW'(ei), !(ed >= 3 && ed <= 12), eb}) begin
              failures++;
              $display("FAIL b2b_rsp r%0d: got id=%0d err=%b bcd=%0d required %0d %b %0d",
                       round, rsp_id, rsp_err, rsp_bcd, ei, !(ed >= 3 && ed <= 12), eb);
            end
          end
          hb = rsp_bcd; hid = rsp_id; he = rsp_err;
        end else begin
          checks++;
          if ({rsp_bcd, rsp_id, rsp_err} !== {hb, hid, he}) begin
            failures++; $display("FAIL b2b_stable r%0d: got bcd=%0d id=%0d required %0d %0d", round, rsp_bcd, rsp_id, hb, hid);
          end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      checks++;
      if (budget >= 400) begin
        failures++; $display("FAIL b2b_timeout r%0d: got pending=%0d required 0", round, exp_id_q.size());
        exp_id_q.delete(); exp_d_q.delete(); do_reset();
      end
    end
    rsp_ready = 1'b1;
  endtask

`ifdef E3_CONV_SELF_CHECK_EN
  task automatic test_self_check();
    do_reset();
    run_req(2, 4'd8);
    checks++;
    if (chk_fail !== 1'b0) begin failures++; $display("FAIL chk_clean: got %b required 0", chk_fail); end
    force_z0 = 1'b1;
    run_req(2, 4'd8);
    force_z0 = 1'b0;
    checks++;
    if (chk_fail !== 1'b1 || rq_bcd !== 4'd0 || rq_lat !== 4) begin
      failures++; $display("FAIL chk_detect: got chk=%b bcd=%0d lat=%0d required 1 0 4", chk_fail, rq_bcd, rq_lat);
    end
    run_req(1, 4'd9);
    checks++;
    if (chk_fail !== 1'b1) begin failures++; $display("FAIL chk_sticky: got %b required 1", chk_fail); end
    do_reset();
    checks++;
    if (chk_fail !== 1'b0) begin failures++; $display("FAIL chk_reset: got %b required 0", chk_fail); end
  endtask
`endif

  initial begin
    #1 Rst = 1'b0;
    test_reset();
    test_single();
    test_invalid();
    test_arbitration();
    test_backpressure();
    test_reset_mid_shift();
    test_exhaustive();
    test_back_to_back();
`ifdef E3_CONV_SELF_CHECK_EN
    test_self_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 required completion");
    $fatal(1, "watchdog");
  end

endmodule
